// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Turns EX-stage taken branch/jal decisions into a PC redirect plus pipeline squash.
// A redirect fires in the same cycle when fetch is ready; otherwise the target is held
// and the front end frozen until fetch_ready_i rises. After every redirect, FETCH_LAT
// cycles of in-flight fetch are squashed through IF/ID.
//
// Ports
//   clk_i            clock, all state on rising edge
//   rst_ni           synchronous active-low reset
//   taken_type_i     00 not taken, 01 branch taken, 10 jal taken, 11 illegal
//   ex_valid_i       EX holds a valid instruction
//   target_pc_i      resolved target from EX
//   stall_i          pipeline-wide stall, EX contents held
//   fetch_ready_i    IF can accept a redirect this cycle
//   redirect_valid_o PC mux selects redirect_pc_o
//   redirect_pc_o    redirect address
//   flush_ifid_o     squash IF/ID
//   flush_idex_o     squash ID/EX
//   stall_req_o      freeze IF..EX while a redirect waits for fetch
//   busy_o           controller is holding or draining
//   br_cnt_o         saturating count of accepted taken branches
//   jal_cnt_o        saturating count of accepted taken jals
//   illegal_seen_o   sticky: taken_type 11 seen with ex_valid in idle
module branch_redirect_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       taken_type_i,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  target_pc_i,
  input  logic             stall_i,
  input  logic             fetch_ready_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] jal_cnt_o,
  output logic             illegal_seen_o
);

  typedef enum logic [1:0] {StIdle, StHold, StDrain} state_e;

  localparam logic [1:0] TypeBr      = 2'b01;
  localparam logic [1:0] TypeJal     = 2'b10;
  localparam logic [1:0] TypeIllegal = 2'b11;

  localparam logic [2:0] DrainLoad = 3'(FETCH_LAT);
  // With no fetch latency a redirect returns straight to idle.
  localparam state_e AfterRedirect = (FETCH_LAT > 0) ? StDrain : StIdle;

  state_e           state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] jal_q, jal_d;
  logic             ill_q, ill_d;

  logic accept;
  logic rv, fi, fx, sr;

  assign accept = ex_valid_i && !stall_i &&
                  ((taken_type_i == TypeBr) || (taken_type_i == TypeJal));

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    hold_pc_d     = hold_pc_q;
    br_d          = br_q;
    jal_d         = jal_q;
    ill_d         = ill_q;
    rv            = 1'b0;
    fi            = 1'b0;
    fx            = 1'b0;
    sr            = 1'b0;
    redirect_pc_o = target_pc_i;

    unique case (state_q)
      StIdle: begin
        if (ex_valid_i && (taken_type_i == TypeIllegal)) begin
          ill_d = 1'b1;
        end
        if (accept) begin
          if ((taken_type_i == TypeBr) && (br_q != '1)) begin
            br_d = br_q + 1'b1;
          end
          if ((taken_type_i == TypeJal) && (jal_q != '1)) begin
            jal_d = jal_q + 1'b1;
          end
          if (fetch_ready_i) begin
            rv      = 1'b1;
            fi      = 1'b1;
            fx      = 1'b1;
            state_d = AfterRedirect;
            drain_d = DrainLoad;
          end else begin
            sr        = 1'b1;
            hold_pc_d = target_pc_i;
            state_d   = StHold;
          end
        end
      end

      StHold: begin
        // EX is frozen by stall_req, so its inputs are not trusted here.
        redirect_pc_o = hold_pc_q;
        if (fetch_ready_i) begin
          rv      = 1'b1;
          fi      = 1'b1;
          fx      = 1'b1;
          state_d = AfterRedirect;
          drain_d = DrainLoad;
        end else begin
          sr = 1'b1;
        end
      end

      StDrain: begin
        fi = 1'b1;
        if (drain_q <= 3'd1) begin
          state_d = StIdle;
          drain_d = 3'd0;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end

      default: begin
        state_d = StIdle;
        drain_d = 3'd0;
      end
    endcase
  end

  // Strobes are forced low while reset is asserted, independent of state.
  assign redirect_valid_o = rst_ni & rv;
  assign flush_ifid_o     = rst_ni & fi;
  assign flush_idex_o     = rst_ni & fx;
  assign stall_req_o      = rst_ni & sr;
  assign busy_o           = rst_ni & (state_q != StIdle);
  assign br_cnt_o         = br_q;
  assign jal_cnt_o        = jal_q;
  assign illegal_seen_o   = ill_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      drain_q   <= 3'd0;
      hold_pc_q <= '0;
      br_q      <= '0;
      jal_q     <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      hold_pc_q <= hold_pc_d;
      br_q      <= br_d;
      jal_q     <= jal_d;
      ill_q     <= ill_d;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a FETCH_LAT=1/CNT_W=16 instance and a FETCH_LAT=0/CNT_W=4
// instance share one stimulus stream. Directed vectors, short hand sequences, then random
// traffic, all checked against an abstract model (pending target + drain cycles left).
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  tt;
  logic        ev;
  logic [31:0] tpc;
  logic        st;
  logic        fr;

  logic        rv1, fi1, fx1, sr1, busy1, ill1;
  logic [31:0] rpc1;
  logic [15:0] br1, jal1;
  logic        rv0, fi0, fx0, sr0, busy0, ill0;
  logic [31:0] rpc0;
  logic [3:0]  br0, jal0;

  int checks   = 0;
  int failures = 0;

  branch_redirect_ctrl #(.XLEN(32), .FETCH_LAT(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .taken_type_i(tt), .ex_valid_i(ev), .target_pc_i(tpc),
    .stall_i(st), .fetch_ready_i(fr), .redirect_valid_o(rv1), .redirect_pc_o(rpc1),
    .flush_ifid_o(fi1), .flush_idex_o(fx1), .stall_req_o(sr1), .busy_o(busy1),
    .br_cnt_o(br1), .jal_cnt_o(jal1), .illegal_seen_o(ill1)
  );

  branch_redirect_ctrl #(.XLEN(32), .FETCH_LAT(0), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .taken_type_i(tt), .ex_valid_i(ev), .target_pc_i(tpc),
    .stall_i(st), .fetch_ready_i(fr), .redirect_valid_o(rv0), .redirect_pc_o(rpc0),
    .flush_ifid_o(fi0), .flush_idex_o(fx0), .stall_req_o(sr0), .busy_o(busy0),
    .br_cnt_o(br0), .jal_cnt_o(jal0), .illegal_seen_o(ill0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          drain;
    bit          hold;
    logic [31:0] hpc;
    int          br;
    int          jal;
    bit          ill;
  } mstate_t;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          fi;
    bit          fx;
    bit          sr;
    bit          busy;
    int          br;
    int          jal;
    bit          ill;
  } mout_t;

  typedef struct {
    bit          rst;
    bit          ev;
    bit [1:0]    tt;
    logic [31:0] pc;
    bit          st;
    bit          fr;
    bit          rv;
    logic [31:0] rpc;
    bit          fi;
    bit          fx;
    bit          sr;
    bit          busy;
    int          br;
    int          jal;
    bit          ill;
  } vec_t;

  mstate_t m1, m0;
  vec_t    vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: a pending target (hold) or a number of squash cycles still owed (drain).
  task automatic model(input mstate_t s, input int fl, input int cmax,
                       output mstate_t n, output mout_t o);
    n      = s;
    o      = '{default: 0};
    o.rpc  = tpc;
    o.br   = s.br;
    o.jal  = s.jal;
    o.ill  = s.ill;
    if (!rst_n) begin
      n = '{default: 0};
      return;
    end
    o.busy = s.hold || (s.drain > 0);
    if (s.hold) begin
      o.rpc = s.hpc;
      if (fr) begin
        o.rv = 1; o.fi = 1; o.fx = 1;
        n.hold  = 0;
        n.drain = fl;
      end else begin
        o.sr = 1;
      end
    end else if (s.drain > 0) begin
      o.fi    = 1;
      n.drain = s.drain - 1;
    end else begin
      if (ev && tt == 2'd3) n.ill = 1;
      if (ev && !st && (tt == 2'd1 || tt == 2'd2)) begin
        if (tt == 2'd1 && s.br < cmax) n.br = s.br + 1;
        if (tt == 2'd2 && s.jal < cmax) n.jal = s.jal + 1;
        if (fr) begin
          o.rv = 1; o.fi = 1; o.fx = 1;
          n.drain = fl;
        end else begin
          o.sr  = 1;
          n.hold = 1;
          n.hpc  = tpc;
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input mout_t e, input logic rv, input logic [31:0] rpc,
                     input logic fi, input logic fx, input logic sr, input logic busy,
                     input logic [15:0] br, input logic [15:0] jal, input logic ill);
    check({tag, "_redirect_valid"}, 64'(rv), 64'(e.rv));
    check({tag, "_flush_ifid"}, 64'(fi), 64'(e.fi));
    check({tag, "_flush_idex"}, 64'(fx), 64'(e.fx));
    check({tag, "_stall_req"}, 64'(sr), 64'(e.sr));
    check({tag, "_busy"}, 64'(busy), 64'(e.busy));
    check({tag, "_br_cnt"}, 64'(br), 64'(e.br));
    check({tag, "_jal_cnt"}, 64'(jal), 64'(e.jal));
    check({tag, "_illegal_seen"}, 64'(ill), 64'(e.ill));
    if (e.rv || e.sr) check({tag, "_redirect_pc"}, 64'(rpc), 64'(e.rpc));
  endtask

  // Inputs are already driven; sample 1ns later, compare, advance model, go to next negedge.
  task automatic step(input bit chk);
    mstate_t n1, n0;
    mout_t   e1, e0;
    #1;
    model(m1, 1, 65535, n1, e1);
    model(m0, 0, 15, n0, e0);
    if (chk) begin
      cmp("m1", e1, rv1, rpc1, fi1, fx1, sr1, busy1, br1, jal1, ill1);
      cmp("m0", e0, rv0, rpc0, fi0, fx0, sr0, busy0, 16'(br0), 16'(jal0), ill0);
    end
    m1 = n1;
    m0 = n0;
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit e, input bit [1:0] t, input logic [31:0] p,
                       input bit s, input bit f);
    rst_n = r; ev = e; tt = t; tpc = p; st = s; fr = f;
  endtask

  initial begin
    m1 = '{default: 0};
    m0 = '{default: 0};
    // rst ev tt pc st fr | rv rpc fi fx sr busy br jal ill   (expectations for FETCH_LAT=1)
    vecs[0]  = '{0, 1, 2'd1, 32'h100, 0, 1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 2'd1, 32'h100, 0, 1, 1, 32'h100, 1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 2'd0, 32'h0,   0, 1, 0, 32'h0,   1, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{1, 0, 2'd0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1, 1, 2'd2, 32'h200, 0, 0, 0, 32'h200, 0, 0, 1, 0, 1, 0, 0};
    vecs[5]  = '{1, 1, 2'd1, 32'h300, 0, 0, 0, 32'h200, 0, 0, 1, 1, 1, 1, 0};
    vecs[6]  = '{1, 1, 2'd1, 32'h400, 1, 0, 0, 32'h200, 0, 0, 1, 1, 1, 1, 0};
    vecs[7]  = '{1, 1, 2'd1, 32'h500, 0, 1, 1, 32'h200, 1, 1, 0, 1, 1, 1, 0};
    vecs[8]  = '{1, 1, 2'd1, 32'h500, 0, 1, 0, 32'h0,   1, 0, 0, 1, 1, 1, 0};
    vecs[9]  = '{1, 0, 2'd0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0, 1, 1, 0};
    vecs[10] = '{1, 1, 2'd1, 32'h600, 1, 1, 0, 32'h0,   0, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{1, 1, 2'd1, 32'h600, 1, 1, 0, 32'h0,   0, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{1, 1, 2'd1, 32'h600, 0, 1, 1, 32'h600, 1, 1, 0, 0, 1, 1, 0};
    vecs[13] = '{1, 0, 2'd0, 32'h0,   0, 1, 0, 32'h0,   1, 0, 0, 1, 2, 1, 0};
    vecs[14] = '{1, 1, 2'd3, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0, 2, 1, 0};
    vecs[15] = '{1, 0, 2'd0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0, 2, 1, 1};
    vecs[16] = '{1, 0, 2'd3, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0, 2, 1, 1};
    vecs[17] = '{1, 1, 2'd1, 32'h700, 0, 0, 0, 32'h700, 0, 0, 1, 0, 2, 1, 1};
    vecs[18] = '{0, 0, 2'd0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0, 3, 1, 1};
    vecs[19] = '{1, 0, 2'd0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0};

    drive(0, 0, 2'd0, 32'h0, 0, 0);
    step(0);
    step(0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].tt, vecs[i].pc, vecs[i].st, vecs[i].fr);
      #1;
      check($sformatf("vec%0d_redirect_valid", i), 64'(rv1), 64'(vecs[i].rv));
      check($sformatf("vec%0d_flush_ifid", i), 64'(fi1), 64'(vecs[i].fi));
      check($sformatf("vec%0d_flush_idex", i), 64'(fx1), 64'(vecs[i].fx));
      check($sformatf("vec%0d_stall_req", i), 64'(sr1), 64'(vecs[i].sr));
      check($sformatf("vec%0d_busy", i), 64'(busy1), 64'(vecs[i].busy));
      check($sformatf("vec%0d_br_cnt", i), 64'(br1), 64'(vecs[i].br));
      check($sformatf("vec%0d_jal_cnt", i), 64'(jal1), 64'(vecs[i].jal));
      check($sformatf("vec%0d_illegal_seen", i), 64'(ill1), 64'(vecs[i].ill));
      if (vecs[i].rv || vecs[i].sr)
        check($sformatf("vec%0d_redirect_pc", i), 64'(rpc1), 64'(vecs[i].rpc));
      step(1);
    end

    // No drain cycle when FETCH_LAT=0.
    drive(1, 1, 2'd2, 32'h800, 0, 1);
    #1;
    check("fl0_redirect", 64'(rv0), 64'd1);
    step(1);
    drive(1, 0, 2'd0, 32'h0, 0, 1);
    #1;
    check("fl0_no_drain_busy", 64'(busy0), 64'd0);
    check("fl0_no_drain_flush", 64'(fi0), 64'd0);
    step(1);

    // Saturation: back-to-back branches, 4-bit counter must stick at 15.
    drive(0, 0, 2'd0, 32'h0, 0, 1);
    step(1);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 2'd1, $urandom, 0, 1);
      step(1);
    end
    drive(1, 0, 2'd0, 32'h0, 0, 1);
    #1;
    check("sat_br_cnt_w4", 64'(br0), 64'd15);
    check("br_cnt_fl1_after_40", 64'(br1), 64'd20);
    step(1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) != 0, $urandom_range(1) == 1, 2'($urandom_range(3)), $urandom,
            $urandom_range(3) == 0, $urandom_range(1) == 1);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
